// File: rtl/mem_clr_pkg.sv
// Shared types and elaboration helpers for the self-clearing RAM.
// The clear engine uses the state type; the top level uses the helpers for its parameter checks.
package mem_clr_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int MIN_READ_LAT = 1;
  localparam int MAX_READ_LAT = 2;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit read_lat_ok(input int lat);
    return (lat >= MIN_READ_LAT) && (lat <= MAX_READ_LAT);
  endfunction

endpackage

// File: rtl/mem_clr_ram_array.sv
// Storage only: one synchronous write port and a read-first registered read port.
// Both ports share a single address.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rd_rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  // Non-blocking update makes a same-edge read return the pre-write word.
  always_ff @(posedge clk) begin
    if (rd_rst) begin
      rd_data_reg <= '0;
    end else if (re) begin
      rd_data_reg <= mem[addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_clr_ram.sv
// Single-port RAM with a hardware clear engine, selectable read latency,
// a read-valid strobe and an error strobe for accesses rejected while clearing.
module mem_clr_ram
  import mem_clr_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_bar,
  input  logic              wr_bar,
  input  logic              decoder_en,
  input  logic              clr_bar,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
      $error("mem_clr_ram: READ_LAT must be 1 or 2");
    end
  endgenerate

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              err_reg;
  logic              valid1_reg;

  logic              wr;
  logic              rd;
  logic              idle;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  assign wr   = decoder_en & ~wr_bar;
  assign rd   = decoder_en & ~rd_bar;
  assign idle = (state_reg == ST_IDLE);

  // The array is never written while reset is held; while clearing it sees only the counter.
  always_comb begin
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = cnt_reg;
    ram_wr_data = '0;
    if (rst_n) begin
      if (idle) begin
        ram_we      = wr;
        ram_re      = rd;
        ram_addr    = addr;
        ram_wr_data = w_data;
      end else begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_CLEAR;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      valid1_reg <= 1'b0;
    end else begin
      err_reg    <= ~idle & (rd | wr);
      valid1_reg <= idle & rd;
      case (state_reg)
        ST_CLEAR: begin
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!clr_bar) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rd_rst  (~rst_n),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .wr_data (ram_wr_data),
    .rd_data (ram_rd_data)
  );

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_data_reg;
      logic              r_valid_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data_reg  <= '0;
          r_valid_reg <= 1'b0;
        end else begin
          r_valid_reg <= valid1_reg;
          if (valid1_reg) begin
            r_data_reg <= ram_rd_data;
          end
        end
      end

      assign r_data  = r_data_reg;
      assign r_valid = r_valid_reg;
    end else begin : g_lat1
      assign r_data  = ram_rd_data;
      assign r_valid = valid1_reg;
    end
  endgenerate

  assign busy = ~idle;
  assign err  = err_reg;

endmodule

// File: tb/tb_mem_clr_ram.sv
// Directed bench: one 8x8 latency-1 instance and one 32x16 latency-2 instance share stimulus.
// Expected values are hand-derived constants; every check is an immediate assertion.
module tb_mem_clr_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  w_data = 8'h00;
  logic [15:0] w_data_b = 16'h0000;
  logic [2:0]  addr = 3'd0;
  logic [4:0]  addr_b;
  logic        rd_bar = 1'b1;
  logic        wr_bar = 1'b1;
  logic        decoder_en = 1'b1;
  logic        clr_bar = 1'b1;

  logic [7:0]  r_data_a;
  logic        r_valid_a, busy_a, err_a;
  logic [15:0] r_data_b;
  logic        r_valid_b, busy_b, err_b;

  int total = 0;
  int bad = 0;

  assign addr_b = {2'b00, addr};

  always #5 clk = ~clk;

  mem_clr_ram #(.DATA_W(8), .ADDR_W(3), .READ_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .w_data(w_data), .addr(addr),
    .rd_bar(rd_bar), .wr_bar(wr_bar), .decoder_en(decoder_en), .clr_bar(clr_bar),
    .r_data(r_data_a), .r_valid(r_valid_a), .busy(busy_a), .err(err_a)
  );

  mem_clr_ram #(.DATA_W(16), .ADDR_W(5), .READ_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .w_data(w_data_b), .addr(addr_b),
    .rd_bar(rd_bar), .wr_bar(wr_bar), .decoder_en(decoder_en), .clr_bar(clr_bar),
    .r_data(r_data_b), .r_valid(r_valid_b), .busy(busy_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_data_b = {8'hC3, d}; wr_bar = 1'b0;
    tick();
    wr_bar = 1'b1;
    chk("wr_err_a", 32'(err_a), 32'd0);
    $display("write addr=%0d data=%02h", a, d);
  endtask

  // Latency-1 result checked after the sampling edge, latency-2 result one edge later.
  task automatic do_read(input logic [2:0] a, input logic [7:0] exp_a, input logic [15:0] exp_b);
    addr = a; rd_bar = 1'b0;
    tick();
    rd_bar = 1'b1;
    chk("rd_valid_a", 32'(r_valid_a), 32'd1);
    chk("rd_data_a", 32'(r_data_a), 32'(exp_a));
    chk("rd_early_b", 32'(r_valid_b), 32'd0);
    tick();
    chk("rd_valid_a_off", 32'(r_valid_a), 32'd0);
    chk("rd_valid_b", 32'(r_valid_b), 32'd1);
    chk("rd_data_b", 32'(r_data_b), 32'(exp_b));
    $display("read addr=%0d a=%02h b=%04h", a, r_data_a, r_data_b);
  endtask

  task automatic busy_run(input string tag);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk({tag, "_busy_a"}, 32'(busy_a), 32'(k < 8));
      chk({tag, "_busy_b"}, 32'(busy_b), 32'(k < 32));
    end
    $display("clear run %s complete", tag);
  endtask

  initial begin
    // Reset held for three edges.
    repeat (3) tick();
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_valid_a", 32'(r_valid_a), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_data_a", 32'(r_data_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_data_b", 32'(r_data_b), 32'd0);
    rst_n = 1'b1;
    busy_run("release");

    // Back-to-back reads of every address after the power-up clear.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        addr = 3'(i); rd_bar = 1'b0;
      end else begin
        rd_bar = 1'b1;
      end
      tick();
      chk("pipe_valid_a", 32'(r_valid_a), 32'(i < 8));
      if (i < 8) chk("pipe_data_a", 32'(r_data_a), 32'd0);
      chk("pipe_valid_b", 32'(r_valid_b), 32'(i > 0));
      if (i > 0) chk("pipe_data_b", 32'(r_data_b), 32'd0);
      $display("pipelined read step %0d", i);
    end
    tick();

    // Basic write then read.
    do_write(3'd7, 8'hAA);
    do_write(3'd5, 8'h1A);
    do_read(3'd7, 8'hAA, 16'hC3AA);
    do_read(3'd5, 8'h1A, 16'hC31A);

    // Simultaneous read and write: read-first.
    addr = 3'd7; w_data = 8'hA3; w_data_b = 16'hC3A3; rd_bar = 1'b0; wr_bar = 1'b0;
    tick();
    rd_bar = 1'b1; wr_bar = 1'b1;
    chk("rw_valid_a", 32'(r_valid_a), 32'd1);
    chk("rw_data_a", 32'(r_data_a), 32'hAA);
    tick();
    chk("rw_valid_b", 32'(r_valid_b), 32'd1);
    chk("rw_data_b", 32'(r_data_b), 32'hC3AA);
    $display("read+write addr=7 old a=%02h", r_data_a);
    do_read(3'd7, 8'hA3, 16'hC3A3);

    // Deselected strobes have no effect.
    decoder_en = 1'b0; addr = 3'd4; w_data = 8'h55; w_data_b = 16'hC355;
    rd_bar = 1'b0; wr_bar = 1'b0;
    tick();
    chk("desel_valid_a", 32'(r_valid_a), 32'd0);
    rd_bar = 1'b1; wr_bar = 1'b1; decoder_en = 1'b1;
    tick();
    chk("desel_valid_b", 32'(r_valid_b), 32'd0);
    $display("deselected access addr=4");
    do_read(3'd4, 8'h00, 16'h0000);

    // Clear on request, with rejected writes during the clear.
    do_write(3'd4, 8'h11);
    do_write(3'd6, 8'h33);
    do_read(3'd4, 8'h11, 16'hC311);
    clr_bar = 1'b0;
    tick();
    clr_bar = 1'b1;
    chk("clr_busy_a", 32'(busy_a), 32'd1);
    chk("clr_busy_b", 32'(busy_b), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      if (k <= 2) begin
        addr = 3'd4; w_data = 8'h77; w_data_b = 16'hC377; wr_bar = 1'b0;
      end else begin
        wr_bar = 1'b1;
      end
      tick();
      chk("clr_err_a", 32'(err_a), 32'(k <= 2));
      chk("clr_err_b", 32'(err_b), 32'(k <= 2));
      chk("clr_run_busy_a", 32'(busy_a), 32'(k < 8));
      chk("clr_run_busy_b", 32'(busy_b), 32'(k < 32));
    end
    $display("clear on request complete");
    do_read(3'd4, 8'h00, 16'h0000);
    do_read(3'd6, 8'h00, 16'h0000);

    // Reset in the middle of a clear restarts it.
    do_write(3'd7, 8'h5C);
    clr_bar = 1'b0;
    tick();
    clr_bar = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mid_busy_a", 32'(busy_a), 32'd1);
    end
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy_a", 32'(busy_a), 32'd1);
    chk("mid_rst_busy_b", 32'(busy_b), 32'd1);
    rst_n = 1'b1;
    busy_run("midclear");
    do_read(3'd7, 8'h00, 16'h0000);

    // Reset between the two read stages drops the pending latency-2 result.
    do_write(3'd2, 8'h6B);
    addr = 3'd2; rd_bar = 1'b0;
    tick();
    rd_bar = 1'b1;
    chk("midrd_valid_a", 32'(r_valid_a), 32'd1);
    chk("midrd_data_a", 32'(r_data_a), 32'h6B);
    rst_n = 1'b0;
    tick();
    chk("midrd_valid_b", 32'(r_valid_b), 32'd0);
    chk("midrd_data_b", 32'(r_data_b), 32'd0);
    chk("midrd_data_a0", 32'(r_data_a), 32'd0);
    rst_n = 1'b1;
    busy_run("midread");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
